selftest_seq: RTL and testbench
===============================

Name: selftest_seq

Overview:
Parametrised power-on self-test sequencer for the LED-matrix, 7-segment and beeper front panel. While the main switch is on, it steps through three phases:
- matrix colour test: red, green, yellow, each blinking;
- all-digit blink test;
- new: a per-digit walking scan.
It then raises finish and holds. Pixel count, digit count, step rate and blink length are parameters. It adds skip-to-done and restart. Tone generation stays in the existing music block, driven by tone_en/tone_sel.

Parameters:
HALF_PERIOD, 500000, clock cycles per blink half-period (step = 2*HALF_PERIOD cycles); legal >= 1
PIXELS, 64, matrix pixels, 2 bits (R,G) each
DIGITS, 8, 7-segment digits, 4-bit code each
BLINK_STEPS, 3, steps in the all-digit blink phase; legal >= 1

Ports:
clk  in  1  system clock
sw  in  1  main switch; synchronous active-low reset (sw=0 resets on the clk edge)
skip  in  1  level, sampled each clk; abort test, go to DONE
restart  in  1  level, sampled each clk; rerun test from DONE
finish  out  1  high in DONE only
matrixData  out  2*PIXELS  pixel data, {R,G} per pixel, same value on every pixel
numbersData  out  4*DIGITS  digit codes, digit DIGITS-1 in the MSBs; 4'hF = blank, 4'h8 = all segments
tone_en  out  1  beeper gate for the music block
tone_sel  out  3  tone index for the music block
step_o  out  $clog2(3+BLINK_STEPS+DIGITS+1)  global step index

Behaviour:
Registered state, all cleared when sw=0 at a clk edge:
- state=IDLE, cnt=0, blink=1, sub=0, step_o=0.

Outputs:
- All outputs are combinational decodes of registered state only; no input reaches an output combinationally.

IDLE:
- matrixData=0, numbersData all F, finish=0, tone_en=0, tone_sel=0.
- First clk edge with sw=1: go to RED with cnt=0, blink=1, sub=0. This is a 1-cycle latency from reset release.

Timing inside RED, GREEN, YELLOW, BLINK and SCAN:
- cnt counts 0..HALF_PERIOD-1.
- When cnt wraps, blink toggles.
- A 1->0 toggle of blink is a half-tick only.
- The 0->1 toggle ends the step: sub/state advance, step_o increments, blink=1.
- Each step is therefore exactly 2*HALF_PERIOD cycles: the first half has blink=1, the second half blink=0.

State sequence:
- RED (1 step) -> GREEN (1) -> YELLOW (1) -> BLINK (BLINK_STEPS) -> SCAN (DIGITS) -> DONE.
- sub counts steps within a multi-step phase and resets to 0 on each phase entry.

Colour phases (RED/GREEN/YELLOW):
- colour is 2'b10 / 2'b01 / 2'b11.
- matrixData = PIXELS copies of (colour AND {blink,blink}).
- numbersData is all F.

BLINK:
- matrixData=0.
- Every digit = 8 when blink=1, else F.

SCAN:
- matrixData=0.
- Digit (DIGITS-1-sub) = 8 steady, with no blink masking.
- All other digits = F.

DONE:
- finish=1, matrixData=0, numbersData all F, tone_en=0.
- Holds until sw=0 or restart.

Tone outputs:
- tone_en = blink in every state except IDLE and DONE.
- tone_sel: RED=0, GREEN=1, YELLOW=2, BLINK=3, SCAN=4, else 0.

skip:
- In any state other than DONE, skip=1 at an edge sends the next state to DONE.
- On that edge: cnt=0, blink=1, step_o unchanged.
- This includes IDLE with sw=1: skip wins over IDLE->RED.

restart:
- In DONE, restart=1 at an edge sends the next state to RED, with cnt=0, blink=1, sub=0, step_o=0.
- restart is ignored in all other states.

Simultaneous events (priority):
- sw=0 beats everything.
- In DONE, restart beats skip.
- Outside DONE, skip beats restart and beats a step-end coinciding with the same edge.

Reset mid-operation:
- Any state returns to IDLE on the next edge.
- Outputs show IDLE values the following cycle.

Arithmetic and widths:
- cnt width is $clog2(HALF_PERIOD+1).
- step_o saturates at 3+BLINK_STEPS+DIGITS, its value in DONE after a full run.
- HALF_PERIOD=1 is legal: blink toggles every cycle.

Test Plan:
1. Full run (HALF_PERIOD=4, DIGITS=8, BLINK_STEPS=3); release sw at edge 0:
   - matrixData = all 2'b10 at cycles 1-4, 0 at cycles 5-8.
   - GREEN at cycle 9, YELLOW at cycle 17, BLINK at cycle 25, SCAN at cycle 49.
   - finish=1 from cycle 113; step_o=14.
2. SCAN walk, same run:
   - cycles 49-56: numbersData=32'h8FFFFFFF.
   - cycles 57-64: 32'hF8FFFFFF.
   - cycles 105-112: 32'hFFFFFFF8.
   - BLINK phase alternates 32'h88888888 / 32'hFFFFFFFF every 4 cycles.
3. Skip during BLINK at cycle 30 -> finish=1 at cycle 31, matrixData=0, tone_en=0, step_o=3.
4. restart in DONE -> next cycle RED, step_o=0, finish=0.
   - restart=1 during GREEN -> no effect.
   - skip=1 and restart=1 together in DONE -> RED.
5. sw=0 at cycle 20 (YELLOW) -> cycle 21: numbersData all F, matrixData=0, tone_en=0.
   - Re-release of sw -> RED again after 1 cycle.
6. Generics: PIXELS=16, DIGITS=4, BLINK_STEPS=1, HALF_PERIOD=1:
   - finish at cycle 1+2*(3+1+4)=17.
   - SCAN codes run 16'h8FFF -> 16'hFFF8.

Source files
------------

// File: rtl/selftest_seq.sv
// selftest_seq: power-on self-test sequencer for the LED matrix, 7-segment digits and beeper.
// Colour phases, an all-digit blink phase and a per-digit walking scan, then DONE.
module selftest_seq #(
  parameter int HALF_PERIOD = 500000,
  parameter int PIXELS = 64,
  parameter int DIGITS = 8,
  parameter int BLINK_STEPS = 3
) (
  input  logic clk,
  input  logic sw,
  input  logic skip,
  input  logic restart,
  output logic finish,
  output logic [2*PIXELS-1:0] matrixData,
  output logic [4*DIGITS-1:0] numbersData,
  output logic tone_en,
  output logic [2:0] tone_sel,
  output logic [$clog2(3+BLINK_STEPS+DIGITS+1)-1:0] step_o
);
  localparam int CW = $clog2(HALF_PERIOD+1);
  localparam int NS = 3+BLINK_STEPS+DIGITS;
  localparam int STW = $clog2(NS+1);
  localparam int BW = $clog2((BLINK_STEPS > DIGITS ? BLINK_STEPS : DIGITS)+1);
  typedef enum logic [2:0] {IDLE, RED, GREEN, YELLOW, BLINK, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic blink, blink_nx;
  logic [BW-1:0] sub, sub_nx;
  logic [STW-1:0] step_nx;
  logic [1:0] colour;
  logic wrap;
  always_ff @(posedge clk)
    if (!sw) begin
      state <= IDLE;
      cnt <= '0;
      blink <= 1'b1;
      sub <= '0;
      step_o <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      blink <= blink_nx;
      sub <= sub_nx;
      step_o <= step_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    blink_nx = blink;
    sub_nx = sub;
    step_nx = step_o;
    wrap = cnt == CW'(HALF_PERIOD-1);
    if (state == DONE) begin
      if (restart) begin
        state_nx = RED;
        cnt_nx = '0;
        blink_nx = 1'b1;
        sub_nx = '0;
        step_nx = '0;
      end
    end else if (skip) begin
      state_nx = DONE;
      cnt_nx = '0;
      blink_nx = 1'b1;
    end else if (state == IDLE) begin
      state_nx = RED;
      cnt_nx = '0;
      blink_nx = 1'b1;
      sub_nx = '0;
    end else if (!wrap) cnt_nx = cnt + 1'b1;
    else begin
      cnt_nx = '0;
      blink_nx = !blink;
      // only the 0->1 toggle closes a step
      if (!blink) begin
        step_nx = step_o == STW'(NS) ? step_o : step_o + 1'b1;
        sub_nx = '0;
        case (state)
          RED: state_nx = GREEN;
          GREEN: state_nx = YELLOW;
          YELLOW: state_nx = BLINK;
          BLINK: if (sub == BW'(BLINK_STEPS-1)) state_nx = SCAN; else sub_nx = sub + 1'b1;
          default: if (sub == BW'(DIGITS-1)) state_nx = DONE; else sub_nx = sub + 1'b1;
        endcase
      end
    end
  end
  always_comb begin
    colour = state == RED ? 2'b10 : state == GREEN ? 2'b01 : state == YELLOW ? 2'b11 : 2'b00;
    matrixData = {PIXELS{colour & {blink, blink}}};
    finish = state == DONE;
    tone_en = blink && state != IDLE && state != DONE;
    tone_sel = state == RED ? 3'd0 : state == GREEN ? 3'd1 : state == YELLOW ? 3'd2 :
               state == BLINK ? 3'd3 : state == SCAN ? 3'd4 : 3'd0;
    numbersData = '1;
    for (int i = 0; i < DIGITS; i++)
      numbersData[4*i +: 4] = (state == BLINK && blink) || (state == SCAN && int'(sub) == DIGITS-1-i) ? 4'h8 : 4'hF;
  end
endmodule

// File: tb/tb_selftest_seq.sv
// tb_selftest_seq: two parameterisations of selftest_seq against a time-based reference model.
module tb_selftest_seq;
  localparam int IDLE_M = 0, RUN_M = 1, DONE_M = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic sw, skip, restart;
  logic fin1, te1, fin2, te2;
  logic [127:0] m1;
  logic [31:0] n1, m2;
  logic [15:0] n2;
  logic [2:0] ts1, ts2;
  logic [3:0] st1, st2;
  int vectors = 0, errors = 0;
  int md1, t1, f1, md2, t2, f2;
  selftest_seq #(.HALF_PERIOD(4), .PIXELS(64), .DIGITS(8), .BLINK_STEPS(3)) dut1 (
    .clk(clk), .sw(sw), .skip(skip), .restart(restart), .finish(fin1), .matrixData(m1),
    .numbersData(n1), .tone_en(te1), .tone_sel(ts1), .step_o(st1));
  selftest_seq #(.HALF_PERIOD(1), .PIXELS(16), .DIGITS(4), .BLINK_STEPS(1)) dut2 (
    .clk(clk), .sw(sw), .skip(skip), .restart(restart), .finish(fin2), .matrixData(m2),
    .numbersData(n2), .tone_en(te2), .tone_sel(ts2), .step_o(st2));
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // t counts cycles since the run began; the step index and blink half follow from it directly
  task automatic model_step(input int hp, input int b, input int d, inout int md, inout int t, inout int f);
    if (!sw) md = IDLE_M;
    else if (md == IDLE_M) begin
      if (skip) begin md = DONE_M; f = 0; end
      else begin md = RUN_M; t = 0; end
    end else if (md == RUN_M) begin
      if (skip) begin md = DONE_M; f = t/(2*hp); end
      else begin
        t++;
        if (t/(2*hp) >= 3+b+d) begin md = DONE_M; f = 3+b+d; end
      end
    end else if (restart) begin md = RUN_M; t = 0; end
  endtask
  task automatic model_out(input int hp, input int b, input int d, input int p, input int md,
                           input int t, input int f, output logic [127:0] m, output logic [31:0] n,
                           output logic fin, output logic te, output logic [2:0] ts, output logic [3:0] st);
    int s, ph;
    logic bl;
    logic [1:0] col;
    s = t/(2*hp);
    bl = (t % (2*hp)) < hp;
    m = '0; n = '0; fin = 1'b0; te = 1'b0; ts = 3'd0; st = 4'd0;
    for (int i = 0; i < d; i++) n[4*i +: 4] = 4'hF;
    if (md == DONE_M) begin
      fin = 1'b1;
      st = 4'(f);
    end else if (md == RUN_M) begin
      ph = s < 3 ? s : s < 3+b ? 3 : 4;
      te = bl;
      ts = 3'(ph);
      st = 4'(s);
      col = ph == 0 ? 2'b10 : ph == 1 ? 2'b01 : ph == 2 ? 2'b11 : 2'b00;
      for (int i = 0; i < p; i++) if (bl) m[2*i +: 2] = col;
      for (int i = 0; i < d; i++)
        if ((ph == 3 && bl) || (ph == 4 && i == d-1-(s-3-b))) n[4*i +: 4] = 4'h8;
    end
  endtask
  task automatic compare_all;
    logic [127:0] m;
    logic [31:0] n;
    logic fin, te;
    logic [2:0] ts;
    logic [3:0] st;
    model_out(4, 3, 8, 64, md1, t1, f1, m, n, fin, te, ts, st);
    check("d1.matrix", m1, m);
    check("d1.numbers", 128'(n1), 128'(n));
    check("d1.finish", 128'(fin1), 128'(fin));
    check("d1.tone_en", 128'(te1), 128'(te));
    check("d1.tone_sel", 128'(ts1), 128'(ts));
    check("d1.step", 128'(st1), 128'(st));
    model_out(1, 1, 4, 16, md2, t2, f2, m, n, fin, te, ts, st);
    check("d2.matrix", 128'(m2), m);
    check("d2.numbers", 128'(n2), 128'(n));
    check("d2.finish", 128'(fin2), 128'(fin));
    check("d2.tone_en", 128'(te2), 128'(te));
    check("d2.tone_sel", 128'(ts2), 128'(ts));
    check("d2.step", 128'(st2), 128'(st));
  endtask
  task automatic tick;
    @(posedge clk);
    model_step(4, 3, 8, md1, t1, f1);
    model_step(1, 1, 4, md2, t2, f2);
    #1;
    compare_all();
  endtask
  initial begin
    sw = 1'b0; skip = 1'b0; restart = 1'b0;
    md1 = IDLE_M; t1 = 0; f1 = 0;
    md2 = IDLE_M; t2 = 0; f2 = 0;
    repeat (2) tick();
    sw = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      tick();
      if (c == 49) check("scan_first", 128'(n1), 128'(32'h8FFFFFFF));
      if (c == 112) check("scan_last", 128'(n1), 128'(32'hFFFFFFF8));
      if (c == 113) begin
        check("done_step", 128'(st1), 128'(14));
        check("done_finish", 128'(fin1), 128'(1));
      end
      if (c == 16) check("d2_prefinish", 128'(fin2), 128'(0));
      if (c == 17) check("d2_finish", 128'(fin2), 128'(1));
    end
    for (int c = 0; c < 4000; c++) begin
      sw = $urandom_range(0, 199) != 0;
      skip = $urandom_range(0, 99) == 0;
      restart = $urandom_range(0, 9) == 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
